// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the tx port scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } sched_state_t;

  localparam int C_DEFAULT_IFG = 12;
  localparam int C_PKT_CNT_W   = 16;

endpackage

// File: rtl/tx_port_scheduler_rr_picker.sv
// rr_picker: combinational round-robin pick. Returns the first set request
// bit at or above ptr, wrapping modulo P_WIDTH.
module rr_picker #(
  parameter int P_WIDTH = 3,
  localparam int IW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1
) (
  input  logic [P_WIDTH-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      index
);

  logic [P_WIDTH-1:0] rot;
  logic [IW:0]        sum;

  // rotate so bit 0 is the requester sitting at ptr
  assign rot = P_WIDTH'({req, req} >> ptr);

  // lowest set bit of the rotated vector, mapped back to an absolute index
  always_comb begin
    valid = 1'b0;
    sum   = '0;
    for (int k = P_WIDTH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(k);
      end
    end
    index = (sum >= (IW+1)'(P_WIDTH)) ? IW'(sum - (IW+1)'(P_WIDTH)) : sum[IW-1:0];
  end

endmodule

// File: rtl/tx_port_scheduler.sv
// tx_port_scheduler: packet-aware round-robin scheduler for one tx port.
// A grant is held for a whole packet (through eof), then an inter-frame gap.
// Optional feature: define TX_SCHED_PKT_CNT_EN to add the pkt_cnt_o counter.
module tx_port_scheduler
  import tx_sched_pkg::*;
#(
  parameter int P_WIDTH      = 3,
  parameter int P_IFG_CYCLES = C_DEFAULT_IFG
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [P_WIDTH-1:0] empty_i,
  input  logic [P_WIDTH-1:0] eof_i,
  output logic [P_WIDTH-1:0] grant_o,
  output logic               tx_ctrl_o,
  output logic               busy_o,
  output logic               underrun_o
`ifdef TX_SCHED_PKT_CNT_EN
  ,
  output logic [C_PKT_CNT_W-1:0] pkt_cnt_o
`endif
);

  localparam int IW = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
  localparam int GW = (P_IFG_CYCLES > 0) ? $clog2(P_IFG_CYCLES + 1) : 1;

  sched_state_t       state_q, state_d;
  logic [IW-1:0]      owner_q, rr_ptr_q, pick_idx;
  logic [GW-1:0]      gap_cnt_q;
  logic [P_WIDTH-1:0] req;
  logic               pick_vld, last_byte;

  assign req = ~empty_i;

  rr_picker #(.P_WIDTH(P_WIDTH)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_vld),
    .index (pick_idx)
  );

  // grant/underrun depend only on registered state/owner and the owner's empty flag
  always_comb begin
    grant_o    = '0;
    underrun_o = 1'b0;
    last_byte  = 1'b0;
    if (state_q == STREAM) begin
      if (!empty_i[owner_q]) begin
        grant_o[owner_q] = 1'b1;
        last_byte        = eof_i[owner_q];
      end else begin
        underrun_o = 1'b1;
      end
    end
  end

  assign tx_ctrl_o = |grant_o;
  assign busy_o    = (state_q != IDLE);

  // next-state: arbitrate in IDLE, hold through eof, then run out the gap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = STREAM;
      STREAM:  if (last_byte) state_d = (P_IFG_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // owner latched at arbitration; rr pointer advances past owner on eof
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (state_q == IDLE && pick_vld) owner_q <= pick_idx;
      if (last_byte) rr_ptr_q <= (owner_q == IW'(P_WIDTH - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  // gap down-counter, loaded on packet end so GAP lasts P_IFG_CYCLES cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  gap_cnt_q <= '0;
    else if (last_byte && P_IFG_CYCLES > 0)     gap_cnt_q <= GW'(P_IFG_CYCLES - 1);
    else if (state_q == GAP && gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
  end

`ifdef TX_SCHED_PKT_CNT_EN
  // completed-packet counter, wraps naturally at 16 bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          pkt_cnt_o <= '0;
    else if (last_byte) pkt_cnt_o <= pkt_cnt_o + 1'b1;
  end
`endif

endmodule
